// File: rtl/output_argmax.sv
// Purpose : snapshot a final-layer score vector and report the argmax digit, its score and the margin to the runner-up.
// Latency : digit_valid rises NUM_CLASSES-1 edges after the accepting edge; one class compared per clock.
// Backpressure: result held stable until digit_ready; scores_ready stays low from accept until the result is consumed.
module output_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 4,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     scores_valid,
    output logic                     scores_ready,
    input  logic signed [DATA_W-1:0] scores [NUM_CLASSES],
    output logic                     digit_valid,
    input  logic                     digit_ready,
    output logic [IDX_W-1:0]         digit,
    output logic signed [DATA_W-1:0] max_score,
    output logic [DATA_W-1:0]        margin,
    output logic [CNT_W-1:0]         frame_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_t state;
    state_t state_nxt;

    logic signed [DATA_W-1:0] snap [NUM_CLASSES];
    logic signed [DATA_W-1:0] best;
    logic signed [DATA_W-1:0] second;
    logic signed [DATA_W-1:0] cur;
    logic signed [DATA_W-1:0] best_nxt;
    logic signed [DATA_W-1:0] second_nxt;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         best_idx;
    logic [IDX_W-1:0]         best_idx_nxt;
    logic                     accept;
    logic                     last;

    assign accept = (state == IDLE) && scores_valid && scores_ready;
    assign last   = (idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept -> scan all classes -> hold result until consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)      state_nxt = SCAN;
            SCAN:    if (last)        state_nxt = DONE;
            DONE:    if (digit_ready) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // One signed compare of the current class against the running best and runner-up;
    // the strict '>' keeps the lowest index among equal maxima.
    always_comb begin
        cur          = snap[idx];
        best_nxt     = best;
        second_nxt   = second;
        best_idx_nxt = best_idx;
        if (cur > best) begin
            second_nxt   = best;
            best_nxt     = cur;
            best_idx_nxt = idx;
        end else if (cur > second) begin
            second_nxt = cur;
        end
    end

    // Snapshot, scan registers, result fields and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                snap[i] <= '0;
            end
            best         <= '0;
            second       <= '0;
            best_idx     <= '0;
            idx          <= '0;
            scores_ready <= 1'b0;
            digit_valid  <= 1'b0;
            digit        <= '0;
            max_score    <= '0;
            margin       <= '0;
            frame_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < NUM_CLASSES; i++) begin
                            snap[i] <= scores[i];
                        end
                        best         <= scores[0];
                        best_idx     <= '0;
                        second       <= MOST_NEG;
                        idx          <= IDX_W'(1);
                        scores_ready <= 1'b0;
                    end else begin
                        // Rises on the first edge after reset release.
                        scores_ready <= 1'b1;
                    end
                end
                SCAN: begin
                    best     <= best_nxt;
                    second   <= second_nxt;
                    best_idx <= best_idx_nxt;
                    idx      <= idx + 1'b1;
                    if (last) begin
                        digit       <= best_idx_nxt;
                        max_score   <= best_nxt;
                        // best >= second, so the wide difference always fits unsigned in DATA_W bits;
                        // the modular subtraction gives the same low bits.
                        margin      <= best_nxt - second_nxt;
                        digit_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (digit_ready) begin
                        digit_valid  <= 1'b0;
                        frame_count  <= frame_count + 1'b1;
                        scores_ready <= 1'b1;
                    end
                end
                default: begin
                    digit_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_argmax.sv
// Purpose : directed check of output_argmax against hand-computed argmax/max/margin results.
// Latency : expects digit_valid exactly 9 edges after the accepting edge.
// Backpressure: holds digit_ready low to check result stability, pulses reset mid-scan.
module tb_output_argmax;

    logic               clk;
    logic               rst_n;
    logic               scores_valid;
    logic               scores_ready;
    logic signed [31:0] scores [10];
    logic               digit_valid;
    logic               digit_ready;
    logic [3:0]         digit;
    logic signed [31:0] max_score;
    logic [31:0]        margin;
    logic [15:0]        frame_count;

    int checks   = 0;
    int failures = 0;
    int exp_frames = 0;
    logic [31:0] vec [10];

    output_argmax #(
        .NUM_CLASSES(10),
        .DATA_W     (32),
        .IDX_W      (4),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scores_valid(scores_valid),
        .scores_ready(scores_ready),
        .scores      (scores),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .digit       (digit),
        .max_score   (max_score),
        .margin      (margin),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  {31'd0, scores_ready}, 32'd0);
        check({tag, "_valid"},  {31'd0, digit_valid},  32'd0);
        check({tag, "_digit"},  {28'd0, digit},        32'd0);
        check({tag, "_max"},    max_score,             32'd0);
        check({tag, "_margin"}, margin,                32'd0);
        check({tag, "_frames"}, {16'd0, frame_count},  32'd0);
    endtask

    // Called at a negedge in IDLE; applies vec, waits for the result, optionally holds it, consumes it.
    task automatic run_vector(input string tag, input logic [3:0] exp_digit, input logic [31:0] exp_max,
                              input logic [31:0] exp_margin, input int hold, input bit scramble);
        int lat;
        check({tag, "_ready_in"}, {31'd0, scores_ready}, 32'd1);
        for (int i = 0; i < 10; i++) scores[i] = vec[i];
        scores_valid = 1'b1;
        @(negedge clk);
        if (!scramble) scores_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (scramble) for (int i = 0; i < 10; i++) scores[i] = 32'h7FFF_FFFF - $urandom_range(0, 3);
            @(negedge clk);
            if (digit_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, 32'd9);
        check({tag, "_digit"},  {28'd0, digit}, {28'd0, exp_digit});
        check({tag, "_max"},    max_score, exp_max);
        check({tag, "_margin"}, margin, exp_margin);
        for (int k = 0; k < hold; k++) begin
            if (scramble) for (int i = 0; i < 10; i++) scores[i] = $urandom;
            @(negedge clk);
            check({tag, "_hold_valid"},  {31'd0, digit_valid},  32'd1);
            check({tag, "_hold_ready"},  {31'd0, scores_ready}, 32'd0);
            check({tag, "_hold_digit"},  {28'd0, digit}, {28'd0, exp_digit});
            check({tag, "_hold_max"},    max_score, exp_max);
            check({tag, "_hold_margin"}, margin, exp_margin);
        end
        scores_valid = 1'b0;
        digit_ready  = 1'b1;
        @(negedge clk);
        digit_ready = 1'b0;
        exp_frames++;
        check({tag, "_consumed"},   {31'd0, digit_valid},  32'd0);
        check({tag, "_frames"},     {16'd0, frame_count},  exp_frames);
        check({tag, "_ready_out"},  {31'd0, scores_ready}, 32'd1);
        check({tag, "_keep_digit"}, {28'd0, digit}, {28'd0, exp_digit});
    endtask

    initial begin
        rst_n        = 1'b0;
        scores_valid = 1'b0;
        digit_ready  = 1'b0;
        for (int i = 0; i < 10; i++) scores[i] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        rst_n = 1'b1;
        #1;
        check("rel_ready_low", {31'd0, scores_ready}, 32'd0);
        @(negedge clk);
        check("rel_ready_high", {31'd0, scores_ready}, 32'd1);

        // digit_ready with nothing pending must not count a frame.
        digit_ready = 1'b1;
        @(negedge clk);
        digit_ready = 1'b0;
        check("idle_ready_frames", {16'd0, frame_count}, 32'd0);
        check("idle_ready_valid",  {31'd0, digit_valid}, 32'd0);

        // 1: clear winner in the middle.
        vec = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'h0005_0000, 32'd8, 32'd9};
        run_vector("t1", 4'd7, 32'h0005_0000, 32'h0004_FFF7, 0, 1'b0);

        // 2: tied maxima, lowest index wins, margin 0.
        for (int i = 0; i < 10; i++) vec[i] = 32'd0;
        vec[2] = 32'h100;
        vec[5] = 32'h100;
        run_vector("t2", 4'd2, 32'h0000_0100, 32'd0, 0, 1'b0);

        // 3: all negative.
        for (int i = 0; i < 10; i++) vec[i] = -((i + 1) * 16);
        run_vector("t3", 4'd0, 32'hFFFF_FFF0, 32'd16, 0, 1'b0);

        // 4: extremes, full-range margin.
        for (int i = 0; i < 9; i++) vec[i] = 32'h8000_0000;
        vec[9] = 32'h7FFF_FFFF;
        run_vector("t4", 4'd9, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);

        // 5: backpressure with inputs changing during scan and hold.
        for (int i = 0; i < 10; i++) vec[i] = 32'd5;
        vec[3] = 32'd100;
        run_vector("t5", 4'd3, 32'd100, 32'd95, 20, 1'b1);

        // 6: reset pulsed while idx==4.
        for (int i = 0; i < 10; i++) scores[i] = 32'd1;
        scores[6] = 32'd50;
        scores_valid = 1'b1;
        @(negedge clk);
        scores_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        exp_frames = 0;
        #1;
        check("midrst_rel_low", {31'd0, scores_ready}, 32'd0);
        @(negedge clk);
        check("midrst_rel_high", {31'd0, scores_ready}, 32'd1);
        check("midrst_no_valid", {31'd0, digit_valid}, 32'd0);

        for (int i = 0; i < 10; i++) vec[i] = -5;
        vec[5] = 32'd1000;
        vec[1] = 32'd999;
        run_vector("t6", 4'd5, 32'd1000, 32'd1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
